rsa_modexp_engine: RTL

- Parametrised, sequential modular-exponentiation engine: result = base^exponent mod modulus.
- Successor to the fixed-16-bit repeated-multiply encrypt/decrypt path. Adds width/exponent parameters, right-to-left square-and-multiply, a start/ready/done handshake, error detection and async reset.
- Sits after the key generators. It is used as encryptor (exponent = public key) or decryptor (exponent = private key).

---
 rtl/rsa_pkg.sv | 26 ++
 rtl/rsa_modexp_engine_if.sv | 27 ++
 rtl/rsa_mod_reduce.sv | 77 +++++++
 rtl/rsa_modexp_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state encoding and timing helpers for the modular-exponentiation
// engine and its restoring reducer.
package rsa_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_EXP_WIDTH = 16;

    // Cycles one restoring reduction takes at the default operand width.
    localparam int RED_CYCLES = 2 * DEFAULT_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RED_BASE,
        MUL,
        SQR,
        DONE
    } state_t;

    // Accept-to-done cycle count of the constant-time build: LOAD and DONE
    // plus one base reduction and two reductions per exponent bit.
    function automatic int modexp_latency(input int width, input int exp_width);
        return 2 + 2 * width * (2 * exp_width + 1);
    endfunction

endpackage

// File: rtl/rsa_modexp_engine_if.sv
// rsa_modexp_engine_if: start/ready/done request bus of the modexp engine.
// The requester uses the master modport, the engine the slave modport.
interface rsa_modexp_engine_if #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) ();

    logic                 start;
    logic [WIDTH-1:0]     base_in;
    logic [EXP_WIDTH-1:0] exp_in;
    logic [WIDTH-1:0]     mod_in;
    logic                 ready;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic                 err;

    modport master (
        output start, base_in, exp_in, mod_in,
        input  ready, done, result, err
    );

    modport slave (
        input  start, base_in, exp_in, mod_in,
        output ready, done, result, err
    );

endinterface

// File: rtl/rsa_mod_reduce.sv
// rsa_mod_reduce: sequential restoring reducer, rem = operand mod modulus.
// One shift-subtract step per cycle, operand MSB first. The go cycle performs
// the first step, so valid pulses exactly 2*WIDTH cycles after go. A new go
// may be issued in the valid cycle (back-to-back reductions). modulus must be
// held stable for the whole reduction and must be non-zero.
module rsa_mod_reduce #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [2*WIDTH-1:0] operand,
    input  logic [WIDTH-1:0]   modulus,
    output logic               busy,
    output logic               valid,
    output logic [WIDTH-1:0]   rem
);

    localparam int STEPS = 2 * WIDTH;
    localparam int CNT_W = $clog2(STEPS);

    logic [2*WIDTH-1:0] op_sh;
    logic [WIDTH-1:0]   rem_q;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic               valid_q;

    // One restoring step: shift the next operand bit into the partial
    // remainder and subtract the modulus when it fits. The partial remainder
    // stays below the modulus, so WIDTH+1 bits cover the shifted value.
    function automatic logic [WIDTH-1:0] red_step(
        input logic [WIDTH-1:0] r,
        input logic             in_bit,
        input logic [WIDTH-1:0] n
    );
        logic [WIDTH:0] t;
        logic [WIDTH:0] d;
        t = {r, in_bit};
        d = t - {1'b0, n};
        red_step = (t >= {1'b0, n}) ? d[WIDTH-1:0] : t[WIDTH-1:0];
    endfunction

    // Step sequencer: go loads the operand and does step one, the remaining
    // steps run while busy, and the last step raises the one-cycle valid.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_sh   <= '0;
            rem_q   <= '0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (go) begin
                rem_q  <= red_step('0, operand[2*WIDTH-1], modulus);
                op_sh  <= {operand[2*WIDTH-2:0], 1'b0};
                cnt    <= CNT_W'(STEPS - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= red_step(rem_q, op_sh[2*WIDTH-1], modulus);
                op_sh <= {op_sh[2*WIDTH-2:0], 1'b0};
                cnt   <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign rem   = rem_q;

endmodule

// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine: result = base^exponent mod modulus by right-to-left
// square-and-multiply over a shared restoring reducer.
// Optional feature macro RSA_MODEXP_EARLY_TERM_EN: when defined, the engine
// finishes as soon as the remaining exponent bits are all zero (variable
// latency, same results). When undefined, every exponent bit is processed and
// the latency is constant: 2 + 2*WIDTH*(2*EXP_WIDTH+1) cycles from accept.
module rsa_modexp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int EXP_WIDTH = DEFAULT_EXP_WIDTH
) (
    input logic                clk,
    input logic                rst,
    rsa_modexp_engine_if.slave bus
);

    localparam int                IDX_W    = $clog2(EXP_WIDTH) + 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(EXP_WIDTH - 1);

    state_t state;
    state_t state_nx;

    // Operands captured at accept; exp_sh shifts right once per SQR so that
    // exp_sh[0] is always exp[idx].
    logic [WIDTH-1:0]     base_r;
    logic [WIDTH-1:0]     mod_r;
    logic [EXP_WIDTH-1:0] exp_sh;
    logic [IDX_W-1:0]     idx;

    // Working values, both kept below the modulus once RED_BASE completes.
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     acc_nx;
    logic [WIDTH-1:0]     b_nx;
    logic [WIDTH-1:0]     mul_a;
    logic [2*WIDTH-1:0]   product;

    logic [WIDTH-1:0]     result_q;
    logic                 err_q;
    logic                 done_q;

    logic                 ready_int;
    logic                 accept;
    logic                 mod_bad;
    logic                 finish_base;
    logic                 finish_sqr;

    logic                 red_go;
    logic [2*WIDTH-1:0]   red_operand;
    logic                 red_busy;
    logic                 red_valid;
    logic [WIDTH-1:0]     red_rem;

    assign ready_int = (state == IDLE) && !red_busy;
    assign accept    = bus.start && ready_int;
    assign mod_bad   = (mod_r < WIDTH'(2));

`ifdef RSA_MODEXP_EARLY_TERM_EN
    // Stop once no set exponent bit is left to multiply in.
    assign finish_base = (exp_sh == '0);
    assign finish_sqr  = (idx == IDX_LAST) || ((exp_sh >> 1) == '0);
`else
    assign finish_base = 1'b0;
    assign finish_sqr  = (idx == IDX_LAST);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and reducer launch; a new reduction starts in the
    // valid cycle of the previous one so the reducer never idles mid-run.
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        red_go   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (mod_bad) begin
                    state_nx = DONE;
                end else begin
                    red_go   = 1'b1;
                    state_nx = RED_BASE;
                end
            end
            RED_BASE: begin
                if (red_valid) begin
                    if (finish_base) begin
                        state_nx = DONE;
                    end else begin
                        red_go   = 1'b1;
                        state_nx = MUL;
                    end
                end
            end
            MUL: begin
                if (red_valid) begin
                    red_go   = 1'b1;
                    state_nx = SQR;
                end
            end
            SQR: begin
                if (red_valid) begin
                    if (finish_sqr) begin
                        state_nx = DONE;
                    end else begin
                        red_go   = 1'b1;
                        state_nx = MUL;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Values acc and b take once the finishing reduction commits; the next
    // operand is formed from them so chained reductions see fresh data.
    always_comb begin
        acc_nx = acc;
        b_nx   = b;
        if (red_valid) begin
            case (state)
                RED_BASE, SQR: b_nx = red_rem;
                MUL:           if (exp_sh[0]) acc_nx = red_rem;
                default:       ;
            endcase
        end
    end

    // After MUL comes SQR (b*b); after RED_BASE or SQR comes MUL (acc*b).
    assign mul_a       = (state == MUL) ? b_nx : acc_nx;
    assign product     = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, b_nx};
    assign red_operand = (state == LOAD) ? {{WIDTH{1'b0}}, base_r} : product;

    // Operand capture, working-value updates and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r   <= '0;
            mod_r    <= '0;
            exp_sh   <= '0;
            idx      <= '0;
            acc      <= '0;
            b        <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        base_r <= bus.base_in;
                        exp_sh <= bus.exp_in;
                        mod_r  <= bus.mod_in;
                    end
                end
                LOAD: begin
                    acc <= WIDTH'(1);
                    b   <= '0;
                    idx <= '0;
                end
                RED_BASE: begin
                    if (red_valid) begin
                        b <= b_nx;
                    end
                end
                MUL: begin
                    if (red_valid) begin
                        acc <= acc_nx;
                    end
                end
                SQR: begin
                    if (red_valid) begin
                        b      <= b_nx;
                        idx    <= idx + IDX_W'(1);
                        exp_sh <= exp_sh >> 1;
                    end
                end
                DONE: begin
                    done_q   <= 1'b1;
                    err_q    <= mod_bad;
                    result_q <= mod_bad ? '0 : acc;
                end
                default: ;
            endcase
        end
    end

    rsa_mod_reduce #(
        .WIDTH (WIDTH)
    ) u_reduce (
        .clk     (clk),
        .rst     (rst),
        .go      (red_go),
        .operand (red_operand),
        .modulus (mod_r),
        .busy    (red_busy),
        .valid   (red_valid),
        .rem     (red_rem)
    );

    assign bus.ready  = ready_int;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule
